// File: rtl/matrix_reader_pkg.sv
// Shared types and constants for the slot selector and the per-matrix ASCII reader.
package matrix_reader_pkg;

  typedef enum logic [3:0] {
    IDLE, SCAN, READ_META, WAIT_META, SEND_HDR,
    START_READER, WAIT_READER, SEND_SEP, DONE
  } sel_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_META, R_META_W, R_RD, R_RD_W, R_DIG, R_DELIM, R_DONE
  } rd_state_t;

  localparam logic [7:0] HDR_HASH   = 8'h23;
  localparam logic [7:0] HDR_NL     = 8'h0A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;

  // Metadata word layout: rows in [31:24], cols in [23:16].
  localparam int META_ROWS_LSB = 24;
  localparam int META_COLS_LSB = 16;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h57 + {4'h0, v});
  endfunction

endpackage

// File: rtl/matrix_reader.sv
// Formats one stored matrix as ASCII: one hex digit per element, space-separated, newline per row.
// state    | meaning
// R_IDLE   | waiting for start
// R_META   | metadata address presented
// R_META_W | metadata returned, rows/cols captured
// R_RD     | element address presented
// R_RD_W   | element returned, digit captured
// R_DIG    | digit byte offered
// R_DELIM  | space or newline offered
// R_DONE   | one-cycle done pulse
module matrix_reader
  import matrix_reader_pkg::*;
#(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ID_WIDTH-1:0]   matrix_id,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [31:0]           bram_data,
  output logic [7:0]            ascii_data,
  output logic                  ascii_valid,
  input  logic                  ascii_ready
);

  rd_state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, off_q, off_d;
  logic [7:0] rows_q, rows_d, cols_q, cols_d, r_q, r_d, c_q, c_d, char_q, char_d;
  logic last_col, last_row, unused_bits;

  assign unused_bits = ^bram_data[15:4];
  assign last_col    = (c_q == cols_q - 8'd1);
  assign last_row    = (r_q == rows_q - 8'd1);
  assign bram_addr   = base_q + off_q;
  assign busy        = (state_q != R_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= R_IDLE;
      base_q  <= '0;
      off_q   <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      r_q     <= '0;
      c_q     <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      r_q     <= r_d;
      c_q     <= c_d;
      char_q  <= char_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    off_d       = off_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    r_d         = r_q;
    c_d         = c_q;
    char_d      = char_q;
    done        = 1'b0;
    ascii_valid = 1'b0;
    ascii_data  = 8'h00;
    case (state_q)
      R_IDLE: if (start) begin
        base_d  = ADDR_WIDTH'(matrix_id) * ADDR_WIDTH'(BLOCK_SIZE);
        off_d   = '0;
        state_d = R_META;
      end
      R_META: state_d = R_META_W;
      R_META_W: begin
        rows_d  = bram_data[META_ROWS_LSB +: 8];
        cols_d  = bram_data[META_COLS_LSB +: 8];
        r_d     = '0;
        c_d     = '0;
        off_d   = ADDR_WIDTH'(1);
        state_d = (rows_d == 8'd0 || cols_d == 8'd0) ? R_DONE : R_RD;
      end
      R_RD: state_d = R_RD_W;
      R_RD_W: begin
        char_d  = hex_char(bram_data[3:0]);
        state_d = R_DIG;
      end
      R_DIG: begin
        ascii_valid = 1'b1;
        ascii_data  = char_q;
        if (ascii_ready) state_d = R_DELIM;
      end
      R_DELIM: begin
        ascii_valid = 1'b1;
        ascii_data  = last_col ? HDR_NL : CHAR_SPACE;
        if (ascii_ready) begin
          off_d = off_q + ADDR_WIDTH'(1);
          if (last_col) begin
            c_d = '0;
            if (last_row) state_d = R_DONE;
            else begin
              r_d     = r_q + 8'd1;
              state_d = R_RD;
            end
          end else begin
            c_d     = c_q + 8'd1;
            state_d = R_RD;
          end
        end
      end
      R_DONE: begin
        done    = 1'b1;
        state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

endmodule

// File: rtl/matrix_reader_sel.sv
// Scans the requested slots, prints a header per populated matrix, delegates formatting to matrix_reader.
// state        | meaning
// IDLE         | waiting for start
// SCAN         | find next requested slot
// READ_META    | slot metadata address presented
// WAIT_META    | metadata returned, decide skip or print
// SEND_HDR     | emit "#<k>\n"
// START_READER | one-cycle start to sub-reader
// WAIT_READER  | sub-reader owns BRAM and ASCII stream
// SEND_SEP     | emit separator bytes
// DONE         | one-cycle done pulse
module matrix_reader_sel
  import matrix_reader_pkg::*;
#(
  parameter int         NUM_SLOTS  = 8,
  parameter int         BLOCK_SIZE = 1152,
  parameter int         ADDR_WIDTH = 14,
  parameter int         SEP_COUNT  = 2,
  parameter logic [7:0] SEP_CHAR   = 8'h0A,
  parameter bit         HEADER_EN  = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_SLOTS-1:0]           slot_mask,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted,
  output logic [$clog2(NUM_SLOTS+1)-1:0] dump_count,
  output logic [ADDR_WIDTH-1:0]          bram_addr,
  input  logic [31:0]                    bram_data,
  output logic [7:0]                     ascii_data,
  output logic                           ascii_valid,
  input  logic                           ascii_ready
);

  localparam int SLOT_W = $clog2(NUM_SLOTS + 1);

  sel_state_t state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d, mask_sh;
  logic [SLOT_W-1:0]    dump_q, dump_d;
  logic                 abort_q, abort_d, abort_any;
  logic [3:0]           idx_q, idx_d;
  logic [7:0]           rows, cols;
  logic                 unused_meta;

  logic                  rd_start, rd_busy, rd_done, rd_valid, rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [7:0]            rd_data;

  matrix_reader #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ID_WIDTH  (SLOT_W)
  ) u_reader (
    .clk        (clk),
    .rst        (rst),
    .start      (rd_start),
    .matrix_id  (slot_q),
    .busy       (rd_busy),
    .done       (rd_done),
    .bram_addr  (rd_addr),
    .bram_data  (bram_data),
    .ascii_data (rd_data),
    .ascii_valid(rd_valid),
    .ascii_ready(rd_ready)
  );

  assign unused_meta = ^bram_data[15:0];
  assign rows        = bram_data[META_ROWS_LSB +: 8];
  assign cols        = bram_data[META_COLS_LSB +: 8];
  assign mask_sh     = mask_q >> slot_q;
  assign abort_any   = abort_q | abort;
  assign busy        = (state_q != IDLE);
  assign aborted     = (state_q == DONE) && abort_q;
  assign dump_count  = dump_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      mask_q  <= '0;
      dump_q  <= '0;
      abort_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      dump_q  <= dump_d;
      abort_q <= abort_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    mask_d      = mask_q;
    dump_d      = dump_q;
    idx_d       = idx_q;
    abort_d     = (state_q == IDLE) ? 1'b0 : (abort_q | abort);
    done        = 1'b0;
    rd_start    = 1'b0;
    rd_ready    = 1'b0;
    ascii_valid = 1'b0;
    ascii_data  = 8'h00;
    bram_addr   = ADDR_WIDTH'(slot_q) * ADDR_WIDTH'(BLOCK_SIZE);
    case (state_q)
      IDLE: if (start) begin
        mask_d  = slot_mask;
        dump_d  = '0;
        slot_d  = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (abort_any || slot_q >= SLOT_W'(NUM_SLOTS)) state_d = DONE;
        else if (mask_sh[0]) state_d = READ_META;
        else if (slot_q == SLOT_W'(NUM_SLOTS - 1)) state_d = DONE;
        else slot_d = slot_q + SLOT_W'(1);
      end
      READ_META: state_d = abort_any ? DONE : WAIT_META;
      WAIT_META: begin
        idx_d = '0;
        if (abort_any) state_d = DONE;
        else if (rows == 8'd0 || cols == 8'd0) begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = SCAN;
        end else state_d = HEADER_EN ? SEND_HDR : START_READER;
      end
      SEND_HDR: begin
        ascii_valid = 1'b1;
        case (idx_q)
          4'd0:    ascii_data = HDR_HASH;
          4'd1:    ascii_data = CHAR_ZERO + 8'(slot_q);
          default: ascii_data = HDR_NL;
        endcase
        if (ascii_ready) begin
          if (abort_any) state_d = DONE;
          else if (idx_q == 4'd2) state_d = START_READER;
          else idx_d = idx_q + 4'd1;
        end
      end
      START_READER: if (!rd_busy) begin
        rd_start = 1'b1;
        state_d  = WAIT_READER;
      end
      WAIT_READER: begin
        bram_addr   = rd_addr;
        ascii_valid = rd_valid;
        ascii_data  = rd_data;
        rd_ready    = ascii_ready;
        if (rd_done) begin
          dump_d = dump_q + SLOT_W'(1);
          idx_d  = 4'(SEP_COUNT);
          if (abort_any) state_d = DONE;
          else if (SEP_COUNT == 0) begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = SCAN;
          end else state_d = SEND_SEP;
        end
      end
      SEND_SEP: begin
        ascii_valid = 1'b1;
        ascii_data  = SEP_CHAR;
        if (ascii_ready) begin
          // idx_q counts remaining separators down to the last one
          if (abort_any) state_d = DONE;
          else if (idx_q <= 4'd1) begin
            slot_d  = slot_q + SLOT_W'(1);
            state_d = SCAN;
          end else idx_d = idx_q - 4'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
